aib_sync_debounce: RTL and testbench

Stable-level qualifier placed directly downstream of the AIB 2/3-flop data synchronizer. It consumes the already-synchronized level, `sync_in`, and does three things:
- Changes its filtered output only after the new level has been held for `DbncCycles` consecutive clocks.
- Emits single-cycle rise and fall pulses when the filtered level changes.
- Optionally counts rejected glitches.

It has no clock-domain crossing of its own. Its input must come from a synchronizer clocked by the same `clk`.

---
 rtl/aib_sync_debounce.sv | 152 +++++++++++++++
 tb/tb_aib_sync_debounce.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/aib_sync_debounce.sv
// Stable-level qualifier behind the AIB data synchronizer: debounced level, edge pulses, glitch count.
// Build option: define AIB_DBNC_GLITCH_CNT_EN to include the saturating glitch counter.
`timescale 1ns/1ps

module aib_sync_debounce #(
  parameter int   DbncCycles     = 4,
  parameter logic ResetVal       = 1'b0,
  parameter int   GlitchCntWidth = 8
) (
  input  logic                      clk,
  input  logic                      rst_in,
  input  logic                      sync_in,
  input  logic                      en,
  input  logic                      glitch_clr,
  output logic                      lvl_out,
  output logic                      rise_pls,
  output logic                      fall_pls,
  output logic                      busy,
  output logic [GlitchCntWidth-1:0] glitch_cnt
);

  localparam int CntW = $clog2(DbncCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DbncCycles);

  if (DbncCycles < 1 || DbncCycles > 255 || GlitchCntWidth < 1 || GlitchCntWidth > 16) begin : g_param_err
    $fatal(1, "aib_sync_debounce: DbncCycles must be 1..255 and GlitchCntWidth 1..16");
  end

  typedef enum logic [1:0] {STB_LO, CHK_HI, STB_HI, CHK_LO} state_t;
  localparam state_t RstState = ResetVal ? STB_HI : STB_LO;

  state_t          state, state_nxt;
  logic [CntW-1:0] cnt, cnt_nxt;
  logic            lvl_nxt, rise_nxt, fall_nxt, glitch_ev;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lvl_nxt   = lvl_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    glitch_ev = 1'b0;
    case (state)
      STB_LO: begin
        if (en && sync_in) begin
          if (DbncCycles == 1) begin
            state_nxt = STB_HI;
            lvl_nxt   = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = CHK_HI;
            cnt_nxt   = CntW'(1);
          end
        end
      end
      CHK_HI: begin
        if (!en) begin
          // Disabling abandons the candidate silently; it is not a glitch.
          state_nxt = lvl_out ? STB_HI : STB_LO;
          cnt_nxt   = '0;
        end else if (sync_in) begin
          if (cnt + CntW'(1) == CntMax) begin
            state_nxt = STB_HI;
            lvl_nxt   = 1'b1;
            rise_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CntW'(1);
          end
        end else begin
          state_nxt = STB_LO;
          cnt_nxt   = '0;
          glitch_ev = 1'b1;
        end
      end
      STB_HI: begin
        if (en && !sync_in) begin
          if (DbncCycles == 1) begin
            state_nxt = STB_LO;
            lvl_nxt   = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = CHK_LO;
            cnt_nxt   = CntW'(1);
          end
        end
      end
      CHK_LO: begin
        if (!en) begin
          state_nxt = lvl_out ? STB_HI : STB_LO;
          cnt_nxt   = '0;
        end else if (!sync_in) begin
          if (cnt + CntW'(1) == CntMax) begin
            state_nxt = STB_LO;
            lvl_nxt   = 1'b0;
            fall_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CntW'(1);
          end
        end else begin
          state_nxt = STB_HI;
          cnt_nxt   = '0;
          glitch_ev = 1'b1;
        end
      end
      default: begin
        state_nxt = RstState;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state    <= RstState;
      cnt      <= '0;
      lvl_out  <= ResetVal;
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lvl_out  <= lvl_nxt;
      rise_pls <= rise_nxt;
      fall_pls <= fall_nxt;
    end
  end

  assign busy = (state == CHK_HI) || (state == CHK_LO);

`ifdef AIB_DBNC_GLITCH_CNT_EN
  logic [GlitchCntWidth-1:0] glitch_cnt_q;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      glitch_cnt_q <= '0;
    end else if (glitch_clr) begin
      glitch_cnt_q <= '0;
    end else if (glitch_ev && (glitch_cnt_q != '1)) begin
      glitch_cnt_q <= glitch_cnt_q + GlitchCntWidth'(1);
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = &{1'b0, glitch_ev, glitch_clr};
  assign glitch_cnt    = '0;
`endif

endmodule

// File: tb/tb_aib_sync_debounce.sv
// Scoreboard bench for aib_sync_debounce: two instances (slow filter / single-cycle filter) against a run-length model.
`timescale 1ns/1ps

module tb_aib_sync_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, sync_in, en, glitch_clr;
  logic lvl_a, rise_a, fall_a, busy_a;
  logic [7:0] gcnt_a;
  logic lvl_b, rise_b, fall_b, busy_b;
  logic [2:0] gcnt_b;

  aib_sync_debounce #(.DbncCycles(4), .ResetVal(1'b0), .GlitchCntWidth(8)) dut_a (
    .clk(clk), .rst_in(rst_in), .sync_in(sync_in), .en(en), .glitch_clr(glitch_clr),
    .lvl_out(lvl_a), .rise_pls(rise_a), .fall_pls(fall_a), .busy(busy_a), .glitch_cnt(gcnt_a)
  );

  aib_sync_debounce #(.DbncCycles(1), .ResetVal(1'b1), .GlitchCntWidth(3)) dut_b (
    .clk(clk), .rst_in(rst_in), .sync_in(sync_in), .en(en), .glitch_clr(glitch_clr),
    .lvl_out(lvl_b), .rise_pls(rise_b), .fall_pls(fall_b), .busy(busy_b), .glitch_cnt(gcnt_b)
  );

  typedef struct packed {
    logic [19:0] a;
    logic [19:0] b;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: the filtered level plus the length of the current run of differing samples.
  int   m_d[2]   = '{4, 1};
  logic m_rv[2]  = '{1'b0, 1'b1};
  int   m_max[2] = '{255, 7};
  logic m_lvl[2];
  int   m_run[2];
  int   m_g[2];

  function automatic logic [19:0] pack(input logic l, input logic r, input logic f,
                                       input logic b, input int g);
    return {l, r, f, b, 16'(g)};
  endfunction

  function automatic logic [19:0] act_a();
    return pack(lvl_a, rise_a, fall_a, busy_a, int'(gcnt_a));
  endfunction

  function automatic logic [19:0] act_b();
    return pack(lvl_b, rise_b, fall_b, busy_b, int'(gcnt_b));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lvl[k] = m_rv[k];
      m_run[k] = 0;
      m_g[k]   = 0;
    end
  endtask

  task automatic model_step(input int k, input logic s, input logic e, input logic c,
                            output logic [19:0] exp_v);
    logic r, f, gl;
    r = 1'b0; f = 1'b0; gl = 1'b0;
    if (e) begin
      if (s != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == m_d[k]) begin
          m_lvl[k] = s;
          r = s;
          f = !s;
          m_run[k] = 0;
        end
      end else begin
        if (m_run[k] > 0) gl = 1'b1;
        m_run[k] = 0;
      end
    end else begin
      m_run[k] = 0;
    end
`ifdef AIB_DBNC_GLITCH_CNT_EN
    if (c) m_g[k] = 0;
    else if (gl && m_g[k] < m_max[k]) m_g[k]++;
`else
    m_g[k] = 0;
`endif
    exp_v = pack(m_lvl[k], r, f, m_run[k] > 0, m_g[k]);
  endtask

  task automatic drive(input logic s, input logic e, input logic c);
    exp_t x;
    @(negedge clk);
    sync_in = s; en = e; glitch_clr = c;
    model_step(0, s, e, c, x.a);
    model_step(1, s, e, c, x.b);
    sb_q.push_back(x);
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s at %0t: got {lvl,rise,fall,busy,gcnt}=%h, expected %h", name, $time, act, exp_v);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_a", act_a(), e.a);
        check("sb_b", act_b(), e.b);
      end
    end
  end

  initial begin
    rst_in = 1'b0; sync_in = 1'b1; en = 1'b0; glitch_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", act_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
    check("reset_b", act_b(), pack(1'b1, 1'b0, 1'b0, 1'b0, 0));
    @(negedge clk);
    rst_in = 1'b1;

    // Held high after reset: b already high stays quiet, a qualifies a clean rise.
    repeat (10) drive(1'b1, 1'b1, 1'b0);
    repeat (6) drive(1'b0, 1'b1, 1'b0);

    // Short candidates, enough to saturate the counter.
    repeat (300) begin
      repeat (3) drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
    end
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    repeat (2) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);

    // Enable freeze during a falling candidate, then restart from zero.
    repeat (6) drive(1'b1, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    repeat (6) drive(1'b0, 1'b1, 1'b0);

    // Reset while a rising candidate sits at count 3.
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    en = 1'b0;
    rst_in = 1'b0;
    #1;
    check("midrst_a", act_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
    check("midrst_b", act_b(), pack(1'b1, 1'b0, 1'b0, 1'b0, 0));
    model_reset();
    @(negedge clk);
    rst_in = 1'b1;

    repeat (400) begin
      logic s, e, c;
      int   len;
      s   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      repeat (len) begin
        e = ($urandom_range(0, 9) != 0);
        c = ($urandom_range(0, 19) == 0);
        drive(s, e, c);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
